// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, memory/writeback stage states,
// flag bit positions and small opcode-classification helpers.
package cpu_pkg;

    // Opcode encoding, shared with the ALU mode field.
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_SUB     = 4'h2;
    localparam logic [3:0] OP_NAND    = 4'h3;
    localparam logic [3:0] OP_SHL     = 4'h4;
    localparam logic [3:0] OP_SHR     = 4'h5;
    localparam logic [3:0] OP_OUT     = 4'h6;
    localparam logic [3:0] OP_IN      = 4'h7;
    localparam logic [3:0] OP_MOVE    = 4'h8;
    localparam logic [3:0] OP_LOAD    = 4'hD;
    localparam logic [3:0] OP_STORE   = 4'hE;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    // Memory/writeback stage states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } mw_state_e;

    // Flag register bit positions.
    localparam int ZN_Z = 1;
    localparam int ZN_N = 0;

    // Opcodes whose ALU result goes straight to the register file.
    function automatic logic is_reg_write(input logic [3:0] op);
        return (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_NAND) ||
               (op == OP_SHL)  || (op == OP_SHR)  || (op == OP_IN)   ||
               (op == OP_MOVE) || (op == OP_LOADIMM);
    endfunction

    // Opcodes that update both Z and N.
    function automatic logic writes_zn_both(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
    endfunction

    // Shifts update only the Z/carry bit.
    function automatic logic writes_z_only(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

    // State entered right after accepting an instruction with this opcode.
    function automatic mw_state_e route_op(input logic [3:0] op);
        if ((op == OP_LOAD) || (op == OP_STORE)) begin
            return ST_MEM;
        end else if (is_reg_write(op) || (op == OP_OUT)) begin
            return ST_WB;
        end else begin
            return ST_IDLE;
        end
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory / writeback stage. Latches the EX result and then performs either a
// data-memory access, an output-port write or a register-file writeback.
// Holds the architectural ZN flags, the output port and a sticky timeout error.
//
// Handshake: an instruction transfers from EX on a rising edge where
// ex_valid && ex_ready; ex_* inputs are sampled only at that edge. ex_ready is
// low only while a memory access is outstanding, and a transfer during the WB
// cycle chains straight into the next instruction with no bubble.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW          = 8,
    parameter int RW          = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic [1:0]    ex_zn,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_en,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic [1:0]    zn,
    output logic [DW-1:0] out_port,
    output logic          out_strobe,
    output logic          mem_err
);

    // Last counter value before giving up; the counter is 0 in the first MEM cycle.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    mw_state_e     state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] result_q, result_d;
    logic [1:0]    zn_in_q, zn_in_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] load_q, load_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [1:0]    zn_q, zn_d;
    logic [DW-1:0] out_port_q, out_port_d;

    logic accept;
    logic in_wb;
    logic in_mem;

    assign in_wb    = (state_q == ST_WB);
    assign in_mem   = (state_q == ST_MEM);
    assign ex_ready = !in_mem;
    assign accept   = ex_valid && ex_ready;

    // Next-state, latch, timeout and architectural-register update logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        zn_in_d    = zn_in_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        load_d     = load_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        zn_d       = zn_q;
        out_port_d = out_port_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_MEM: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    // An ack on the final allowed cycle still completes normally.
                    cnt_d = 8'd0;
                    if (op_q == OP_LOAD) begin
                        load_d  = mem_rdata;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (writes_zn_both(op_q)) begin
                    zn_d = zn_in_q;
                end else if (writes_z_only(op_q)) begin
                    zn_d[ZN_Z] = zn_in_q[ZN_Z];
                end
                if (op_q == OP_OUT) begin
                    out_port_d = result_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new instruction can arrive in IDLE or WB; it overrides the default route.
        if (accept) begin
            op_d     = ex_opcode;
            result_d = ex_result;
            zn_in_d  = ex_zn;
            rd_d     = ex_rd;
            addr_d   = ex_addr;
            cnt_d    = 8'd0;
            state_d  = route_op(ex_opcode);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            result_q   <= '0;
            zn_in_q    <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            load_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            zn_q       <= '0;
            out_port_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            result_q   <= result_d;
            zn_in_q    <= zn_in_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            zn_q       <= zn_d;
            out_port_q <= out_port_d;
        end
    end

    // Output decode: memory signals only in MEM, pulses only in WB.
    always_comb begin
        mem_req    = in_mem;
        mem_we     = in_mem && (op_q == OP_STORE);
        mem_addr   = in_mem ? addr_q : '0;
        mem_wdata  = (in_mem && (op_q == OP_STORE)) ? result_q : '0;
        wb_en      = in_wb && (is_reg_write(op_q) || (op_q == OP_LOAD));
        wb_rd      = wb_en ? rd_q : '0;
        wb_data    = '0;
        if (wb_en) begin
            wb_data = (op_q == OP_LOAD) ? load_q : result_q;
        end
        out_strobe = in_wb && (op_q == OP_OUT);
        zn         = zn_q;
        out_port   = out_port_q;
        mem_err    = err_q;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Stage directly downstream of the EX-stage ALU in the 8-bit CPU.
- Latches the ALU result, opcode, destination register and ZN flags, then does one of the following: a data-memory access (LOAD/STORE), an OUT port write, or a register-file writeback.
- Owns the architectural ZN flag register and the output port register.
- Back-pressures EX through a ready/valid handshake while a memory access is outstanding.

Parameters:
- DW, 8: datapath width (ALU result, memory data, memory address).
- RW, 2: register-file index width (4 GPRs).
- MEM_TIMEOUT, 15: cycles to wait for mem_ack before aborting; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage can accept this cycle.
- ex_opcode  in  4  opcode, same encoding as the ALU mode field.
- ex_result  in  DW  ALU result; the STORE data when opcode is STORE.
- ex_zn  in  2  ALU flags; [1]=Z/carry-out, [0]=N.
- ex_rd  in  RW  destination register.
- ex_addr  in  DW  memory address (rb value) for LOAD/STORE.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1=write (STORE), 0=read (LOAD).
- mem_addr  out  DW  memory address.
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  load data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- wb_en  out  1  register-file write enable.
- wb_rd  out  RW  write index.
- wb_data  out  DW  write data.
- zn  out  2  architectural flag register.
- out_port  out  DW  registered output port.
- out_strobe  out  1  one-cycle pulse when out_port updates.
- mem_err  out  1  sticky flag, set on memory timeout.

Behaviour:
- Opcodes:
  - Register-writing: 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 7 IN, 8 MOVE, F LOADIMM.
  - D LOAD; E STORE; 6 OUT.
  - 0 and all others: NOP (accepted, no side effects).
- Reset values: every output 0; state IDLE; timeout counter 0; mem_err cleared.
- Handshake: a transfer occurs when ex_valid && ex_ready at a clock edge. Inputs are sampled only at that edge.
- ex_ready = 1 in IDLE and in WB; 0 in MEM.
- States:
  - IDLE: on transfer, latch all ex_* fields.
    - LOAD/STORE -> MEM.
    - Register-writing or OUT -> WB.
    - NOP -> IDLE.
  - MEM: mem_req=1. mem_we, mem_addr and mem_wdata are held stable from the latched fields. The counter increments each cycle.
    - mem_ack with LOAD -> WB; the write data is mem_rdata, captured that cycle.
    - mem_ack with STORE -> IDLE.
    - Counter reaches MEM_TIMEOUT with no ack -> IDLE, mem_err<=1, no writeback.
    - mem_req deasserts the cycle after leaving MEM.
  - WB (exactly one cycle):
    - Register-writing op or LOAD: wb_en=1, wb_rd=latched rd. wb_data=latched result, or the captured load data for LOAD.
    - OUT: out_port<=latched result; out_strobe=1; wb_en=0.
    - Flags: ADD/SUB/NAND write zn<=ex_zn (both bits); SHL/SHR write zn[1] only; all other opcodes leave zn unchanged. zn is visible the cycle after WB.
    - A transfer in WB chains directly to the next state with no bubble. Otherwise WB -> IDLE.
- Latency: ALU-type accepted at edge N gives wb_en high in cycle N+1. LOAD with ack in cycle M gives wb_en high in cycle M+1.
- Throughput: 1 instr/cycle for non-memory ops.
- wb_en and out_strobe are single-cycle pulses, never asserted outside WB.
- mem_ack outside MEM is ignored.
- mem_ack in the same cycle the counter hits MEM_TIMEOUT: the ack wins; no error.
- mem_err clears only on rst.
- rst mid-MEM: mem_req drops the next cycle and the transaction is abandoned; the memory must tolerate this.
- rst in WB suppresses that cycle's wb_en, flag update and out_strobe effects on the following edge; all state returns to reset values.

Decomposition:
- cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_LOADIMM, OP_LOAD=4'hD, OP_STORE=4'hE, OP_OUT=4'h6);
  - the 2-bit state encoding (IDLE, MEM, WB);
  - the flag bit indices (ZN_Z=1, ZN_N=0).
- No sub-module required; the timeout counter and flag register stay inline.

Test Plan:
- ADD: ex_opcode=1, ex_result=8'h2A, ex_zn=2'b10, ex_rd=2. Required: next cycle wb_en=1, wb_rd=2, wb_data=8'h2A; following cycle zn=2'b10.
- Back-to-back MOVE rd=1 (8'h11) then LOADIMM rd=3 (8'hF0) on consecutive cycles. Required: wb_en high two consecutive cycles with (1, 8'h11) then (3, 8'hF0); ex_ready stays 1.
- LOAD: ex_addr=8'h40, ex_rd=0; ack after 3 cycles with mem_rdata=8'h5C. Required: mem_req=1, mem_we=0, mem_addr=8'h40 for 3 cycles and ex_ready=0; next cycle wb_en=1, wb_rd=0, wb_data=8'h5C.
- STORE: ex_result=8'h77, ex_addr=8'h10; ack after 1 cycle. Required: mem_we=1, mem_wdata=8'h77; no wb_en; zn unchanged.
- Timeout: LOAD with mem_ack never asserted and MEM_TIMEOUT=15. Required: mem_req high 15 cycles, then low; mem_err=1 and stays 1; no wb_en.
- SHL with ex_zn=2'b01 and prior zn=2'b00 -> zn=2'b00. Then OUT with ex_result=8'hA5 -> out_port=8'hA5 with a one-cycle out_strobe. Then rst asserted mid-LOAD -> mem_req low next cycle and all outputs at reset values.
